// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_pkg                                        |
// | Description : Shared constants and dump-engine state encoding    |
// |               for the bypassing register file.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package regfile_pkg;

   // Default geometry: 32 x 32-bit registers addressed by 5 bits
   localparam int C_DEF_DATA_W = 32;
   localparam int C_DEF_ADDR_W = 5;
   localparam int C_DEF_DEPTH  = 32;

   // Dump engine states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_dump_fsm                                   |
// | Description : Serial register-dump engine. Walks every index,    |
// |               presenting one valid/ready beat per register, then |
// |               pulses done for one cycle. Owns the beat snapshot. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int DATA_W = C_DEF_DATA_W,
   parameter int ADDR_W = C_DEF_ADDR_W,
   parameter int DEPTH  = C_DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_ready,
   // index the parent should look up (bypassed) for the next snapshot load
   output logic [ADDR_W-1:0] o_look_idx,
   input  logic [DATA_W-1:0] i_look_data,
   output logic              o_busy,
   output logic              o_valid,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_idx,
   output logic [DATA_W-1:0] o_data
);

   localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);

   dump_state_t       r_state;
   dump_state_t       w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic [DATA_W-1:0] r_snap;
   logic              w_load;

   // State, beat index and snapshot registers; the snapshot only changes
   // when a new index is entered, so a stalled beat holds its value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_snap  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_load) begin
            r_snap <= i_look_data;
         end
      end
   end

   // Next-state, next-index and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      o_look_idx  = r_idx + ADDR_W'(1);
      o_valid     = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         IDLE: begin
            o_look_idx = '0;
            if (i_start) begin
               w_state_nxt = SEND;
               w_idx_nxt   = '0;
               w_load      = 1'b1;
            end
         end
         SEND: begin
            o_valid = 1'b1;
            if (i_ready) begin
               if (r_idx == C_LAST_IDX) begin
                  w_state_nxt = DONE;
               end else begin
                  // the lookup is bypassed, so a write this cycle is captured
                  w_idx_nxt = o_look_idx;
                  w_load    = 1'b1;
               end
            end
         end
         DONE: begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_busy = (r_state != IDLE);
   assign o_idx  = r_idx;
   assign o_data = r_snap;

endmodule : regfile_dump_fsm
`default_nettype wire

// File: rtl/regfile_bypass_dbg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_bypass_dbg                                 |
// | Description : DEPTH x DATA_W register file with NRD combinational |
// |               read ports, one synchronous write port, optional   |
// |               hardwired zero register, write-to-read bypass and  |
// |               a handshaked serial debug-dump engine.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module regfile_bypass_dbg
   import regfile_pkg::*;
#(
   parameter int DATA_W   = C_DEF_DATA_W,
   parameter int ADDR_W   = C_DEF_ADDR_W,
   parameter int DEPTH    = C_DEF_DEPTH,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  dump_start,
   output logic                  dump_busy,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_W-1:0]     dump_idx,
   output logic [DATA_W-1:0]     dump_data,
   output logic                  dump_done
);

   // Bits needed to index the storage array itself
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_legal;
   // read lookups: ports 0..NRD-1 are the external ports, slot NRD is the
   // dump engine's snapshot lookup
   logic [ADDR_W-1:0] w_raddr [NRD+1];
   logic [DATA_W-1:0] w_rdata [NRD+1];
   logic [ADDR_W-1:0] w_look_idx;
   logic [DATA_W-1:0] w_look_data;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   // A write lands only for an existing, non-hardwired register
   assign w_wr_legal = wr_en && addr_in_range(wr_addr) &&
                       !((ZERO_REG != 0) && (wr_addr == '0));

   // Storage array: cleared on reset, single write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_legal) begin
         r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd_port
      assign w_raddr[k]                  = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = w_rdata[k];
   end

   assign w_raddr[NRD] = w_look_idx;
   assign w_look_data  = w_rdata[NRD];

   // Same read priority for every lookup: zero reg, out of range, bypass,
   // then storage
   for (genvar k = 0; k <= NRD; k++) begin : g_rd_mux
      assign w_rdata[k] =
         ((ZERO_REG != 0) && (w_raddr[k] == '0))                  ? '0      :
         (!addr_in_range(w_raddr[k]))                             ? '0      :
         ((BYPASS != 0) && w_wr_legal && (wr_addr == w_raddr[k])) ? wr_data :
                                                         r_mem[w_raddr[k][IDX_W-1:0]];
   end

   regfile_dump_fsm #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_dump_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_start     (dump_start),
      .i_ready     (dump_ready),
      .o_look_idx  (w_look_idx),
      .i_look_data (w_look_data),
      .o_busy      (dump_busy),
      .o_valid     (dump_valid),
      .o_done      (dump_done),
      .o_idx       (dump_idx),
      .o_data      (dump_data)
   );

endmodule : regfile_bypass_dbg
`default_nettype wire

// File: tb/tb_regfile_bypass_dbg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_regfile_bypass_dbg                              |
// | Description : Self-checking bench for regfile_bypass_dbg. A      |
// |               register model feeds a scoreboard queue of dump    |
// |               beats that is drained as beats are accepted.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_regfile_bypass_dbg;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int DEP = 32;
   localparam int NR  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR*AW-1:0] rd_addr = '0;
   logic [NR*DW-1:0] rd_data;
   logic [NR*DW-1:0] nb_rd_data;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [DW-1:0]    wr_data = '0;
   logic             dump_start = 1'b0;
   logic             dump_ready = 1'b1;
   logic             dump_busy, dump_valid, dump_done;
   logic [AW-1:0]    dump_idx;
   logic [DW-1:0]    dump_data;
   logic             nb_busy, nb_valid, nb_done;
   logic [AW-1:0]    nb_idx;
   logic [DW-1:0]    nb_data;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0]    mdl [DEP];
   logic [AW+DW-1:0] sb_q [$];

   // default configuration: zero register and bypass enabled
   regfile_bypass_dbg #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NRD(NR), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
      .dump_done(dump_done)
   );

   // plain configuration: no zero register, no bypass
   regfile_bypass_dbg #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NRD(NR), .ZERO_REG(0), .BYPASS(0)
   ) dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dump_start(1'b0), .dump_busy(nb_busy), .dump_valid(nb_valid),
      .dump_ready(1'b0), .dump_idx(nb_idx), .dump_data(nb_data),
      .dump_done(nb_done)
   );

   always #5 clk = ~clk;

   // all tasks start and end 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
      if (a != '0) mdl[a] = d;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEP; i++) mdl[i] = '0;
   endtask

   task automatic push_dump_expect();
      sb_q.delete();
      for (int i = 0; i < DEP; i++) sb_q.push_back({AW'(i), mdl[i]});
   endtask

   task automatic start_dump();
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
   endtask

   // Drain a running dump: pop/compare every accepted beat, verify stalled
   // beats hold, count busy/done cycles. cw injects the two writes while
   // beat 1 is stalled.
   task automatic drain_dump(input bit bp, input bit cw, input int exp_busy);
      int               busy_cyc = 0;
      int               done_cnt = 0;
      int               stage    = 0;
      bit               seen_busy = 1'b0;
      bit               stalled   = 1'b0;
      bit               finished  = 1'b0;
      logic [AW-1:0]    p_idx  = '0;
      logic [DW-1:0]    p_data = '0;
      logic [AW+DW-1:0] exp;
      for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
         @(negedge clk);
         if (dump_busy) begin busy_cyc++; seen_busy = 1'b1; end
         if (dump_done) done_cnt++;
         if (stalled) begin
            checks++;
            if ({dump_idx, dump_data} !== {p_idx, p_data}) begin
               errors++;
               $display("FAIL stall_hold: got idx=%0d data=%h, required idx=%0d data=%h",
                        dump_idx, dump_data, p_idx, p_data);
            end
         end
         stalled = 1'b0;
         if (dump_valid && dump_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got idx=%0d data=%h, required no beat", dump_idx, dump_data);
            end else begin
               exp = sb_q.pop_front();
               if ({dump_idx, dump_data} !== exp) begin
                  errors++;
                  $display("FAIL beat: got idx=%0d data=%h, required idx=%0d data=%h",
                           dump_idx, dump_data, exp[AW+DW-1:DW], exp[DW-1:0]);
               end
            end
         end else if (dump_valid) begin
            stalled = 1'b1; p_idx = dump_idx; p_data = dump_data;
         end
         if (seen_busy && !dump_busy) begin
            finished = 1'b1;
         end else begin
            step();
            wr_en      = 1'b0;
            dump_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cw) begin
               if (stage == 0 && dump_idx == AW'(1)) begin
                  dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 1; wr_data = 32'h0000_BBBB; stage = 1;
               end else if (stage == 1) begin
                  dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_AAAA; stage = 2;
               end
            end
         end
      end
      step();
      wr_en = 1'b0;
      dump_ready = 1'b1;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL dump_timeout: got busy_seen=%0d, required dump to end", seen_busy);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_beats: got %0d beats left, required 0", sb_q.size());
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL done_pulses: got %0d, required 1", done_cnt);
      end
      if (exp_busy != 0) begin
         checks++;
         if (busy_cyc != exp_busy) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, required %0d", busy_cyc, exp_busy);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({dump_busy, dump_valid, dump_done, dump_idx, dump_data} !== '0) begin
         errors++;
         $display("FAIL reset_dump_outs: got busy=%b valid=%b done=%b idx=%0d data=%h, required all 0",
                  dump_busy, dump_valid, dump_done, dump_idx, dump_data);
      end
      step();
      write_reg(5, 32'h0000_1234);
      set_rd(5, 5);
      @(negedge clk);
      checks++;
      if (rd_data[DW-1:0] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL preload_r5: got %h, required %h", rd_data[DW-1:0], 32'h0000_1234);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL async_reset_read: got %h, required 0", rd_data);
      end
      checks++;
      if ({dump_busy, dump_valid, dump_done, dump_idx, dump_data} !== '0) begin
         errors++;
         $display("FAIL async_reset_dump: got busy=%b valid=%b done=%b, required all 0",
                  dump_busy, dump_valid, dump_done);
      end
      clear_model();
      @(posedge clk);
      #3 rst = 1'b0;
      step();
   endtask

   task automatic test_write_bypass();
      wr_en = 1'b1; wr_addr = 8; wr_data = 32'hDEAD_BEEF;
      set_rd(8, 9);
      #2;
      checks++;
      if (rd_data[DW-1:0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass_p0: got %h, required %h", rd_data[DW-1:0], 32'hDEAD_BEEF);
      end
      checks++;
      if (rd_data[2*DW-1:DW] !== mdl[9]) begin
         errors++;
         $display("FAIL bypass_other_port: got %h, required %h", rd_data[2*DW-1:DW], mdl[9]);
      end
      checks++;
      if (nb_rd_data[DW-1:0] !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_p0: got %h, required 0", nb_rd_data[DW-1:0]);
      end
      step();
      wr_en  = 1'b0;
      mdl[8] = 32'hDEAD_BEEF;
      set_rd(9, 8);
      #2;
      checks++;
      if (rd_data[2*DW-1:DW] !== mdl[8]) begin
         errors++;
         $display("FAIL after_write_p1: got %h, required %h", rd_data[2*DW-1:DW], mdl[8]);
      end
      checks++;
      if (nb_rd_data[2*DW-1:DW] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL nobypass_after_p1: got %h, required %h", nb_rd_data[2*DW-1:DW], 32'hDEAD_BEEF);
      end
      step();
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
      set_rd(0, 0);
      #2;
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL zero_during_write: got %h, required 0", rd_data);
      end
      step();
      wr_en = 1'b0;
      #2;
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL zero_after_write: got %h, required 0", rd_data);
      end
      checks++;
      if (nb_rd_data !== {2{32'hFFFF_FFFF}}) begin
         errors++;
         $display("FAIL nozero_after_write: got %h, required %h", nb_rd_data, {2{32'hFFFF_FFFF}});
      end
      step();
   endtask

   task automatic test_full_dump();
      for (int i = 1; i < DEP; i++) write_reg(AW'(i), 32'(i * 32'h11));
      push_dump_expect();
      dump_ready = 1'b1;
      start_dump();
      drain_dump(1'b0, 1'b0, DEP + 1);
   endtask

   task automatic test_backpressure();
      // reg 3 is rewritten before its beat is loaded; reg 1 after its snapshot
      mdl[3] = 32'h0000_AAAA;
      push_dump_expect();
      dump_ready = 1'b1;
      start_dump();
      drain_dump(1'b1, 1'b1, 0);
      mdl[1] = 32'h0000_BBBB;
      set_rd(1, 3);
      #2;
      checks++;
      if (rd_data !== {mdl[3], mdl[1]}) begin
         errors++;
         $display("FAIL concurrent_writes: got %h, required %h", rd_data, {mdl[3], mdl[1]});
      end
      step();
   endtask

   task automatic test_reset_mid_dump();
      int done_cnt = 0;
      dump_ready = 1'b1;
      start_dump();
      for (int c = 0; c < 100 && dump_idx != AW'(10); c++) step();
      checks++;
      if (dump_idx !== AW'(10)) begin
         errors++;
         $display("FAIL reach_idx10: got %0d, required 10", dump_idx);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({dump_busy, dump_valid, dump_done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_outs: got busy=%b valid=%b done=%b, required 000",
                  dump_busy, dump_valid, dump_done);
      end
      clear_model();
      @(posedge clk);
      #3 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dump_done || dump_busy) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d busy/done cycles, required 0", done_cnt);
      end
      step();
      push_dump_expect();
      start_dump();
      drain_dump(1'b0, 1'b0, DEP + 1);
   endtask

   initial begin
      clear_model();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_write_bypass();
      test_zero_reg();
      test_full_dump();
      test_backpressure();
      test_reset_mid_dump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_bypass_dbg
`default_nettype wire
